// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests and buffers returned
// instructions in order for decode. Define IFQ_BYPASS_EN to forward a response straight to decode.
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]            fetch_pc;
   logic [DEPTH-1:0][31:0] q_pc;
   logic [DEPTH-1:0][31:0] q_data;
   logic [DEPTH-1:0]       q_filled;
   logic [PW-1:0]          head, tail, fill_ptr;
   logic [CW-1:0]          alloc_cnt, drop_cnt, filled_cnt, unfilled_cnt;
   logic [CW:0]            credit_used;
   logic [31:0]            redir_aligned;
   logic                   req_fire, rsp_drop, rsp_fill, pop;

   assign redir_aligned = redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      filled_cnt = '0;
      for (int i = 0; i < DEPTH; i++)
         filled_cnt = filled_cnt + CW'(q_filled[i]);
   end

   // Allocated entries still waiting for data; these become stale responses on a redirect.
   assign unfilled_cnt = alloc_cnt - filled_cnt;

   assign credit_used    = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
   assign imem_addr      = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_fill = imem_rsp_valid && (drop_cnt == '0);

   always_comb begin
      instr_valid = q_filled[head];
      instr       = q_filled[head] ? q_data[head] : 32'h0;
      instr_pc    = q_filled[head] ? q_pc[head]   : 32'h0;
`ifdef IFQ_BYPASS_EN
      // Responses fill the oldest unfilled entry, so an unfilled head is exactly the target.
      if (!q_filled[head] && (alloc_cnt != '0) && rsp_fill && !redirect_valid) begin
         instr_valid = 1'b1;
         instr       = imem_rsp_data;
         instr_pc    = q_pc[head];
      end
`endif
   end

   assign pop = instr_valid && instr_ready && !redirect_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc  <= RESET_PC;
         q_pc      <= '0;
         q_data    <= '0;
         q_filled  <= '0;
         head      <= '0;
         tail      <= '0;
         fill_ptr  <= '0;
         alloc_cnt <= '0;
         drop_cnt  <= '0;
      end else if (redirect_valid) begin
         fetch_pc  <= redir_aligned;
         q_filled  <= '0;
         head      <= '0;
         tail      <= '0;
         fill_ptr  <= '0;
         alloc_cnt <= '0;
         drop_cnt  <= drop_cnt + unfilled_cnt - CW'(imem_rsp_valid);
      end else begin
         if (req_fire) begin
            q_pc[tail] <= fetch_pc;
            tail       <= tail + PW'(1);
            fetch_pc   <= fetch_pc + 32'd4;
         end
         if (rsp_drop)
            drop_cnt <= drop_cnt - CW'(1);
         if (rsp_fill) begin
            q_data[fill_ptr]   <= imem_rsp_data;
            q_filled[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + PW'(1);
         end
         // Placed after the fill so a bypassed-and-popped head ends up not filled.
         if (pop) begin
            q_filled[head] <= 1'b0;
            head           <= head + PW'(1);
         end
         alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(pop);
      end
   end

endmodule
